// File: rtl/cabac_bin_encoder.sv
// CABAC arithmetic bin encoder: codes regular and bypass bins into a serial
// bitstream, one renormalisation step or one output bit per clock.
module cabac_bin_encoder #(
    parameter int OUTS_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bin_valid,
    output logic       bin_ready,
    input  logic       bin_in,
    input  logic       bypass,
    input  logic [7:0] pState_in,
    input  logic       flush,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       done,
    output logic       overflow_err,
    output logic [8:0] m_range_out,
    output logic [9:0] m_low_out
);
    typedef enum logic [1:0] {IDLE, RENORM, EMIT, FLUSH_TAIL} state_t;

    localparam logic [OUTS_W-1:0] OUTS_MAX = '1;
    localparam logic [OUTS_W-1:0] OUTS_ONE = OUTS_W'(1);

    state_t            state, state_nxt, ret_state, ret_nxt, after_put;
    logic [8:0]        range_q, range_nxt, lps, rmps;
    logic [9:0]        low_q, low_nxt, ren_l;
    logic [10:0]       low_sum, byp_t;
    logic [OUTS_W-1:0] outs_q, outs_nxt;
    logic              first_bit, first_nxt;
    logic              flushing, flushing_nxt;
    logic              flush_pend, flush_pend_nxt;
    logic [1:0]        tail_phase, tail_nxt;
    logic              emit_val, emit_val_nxt;
    logic              ovf_nxt, bv_nxt, bo_nxt, last_nxt, last_q;
    logic              put_req, put_b, inc_req;
    logic              unused_pstate_lsb;

    // LPS sub-range from the probability index (MPS-folded) and range[8:5]
    function automatic logic [8:0] lps_range(input logic [5:0] ps_hi, input logic [3:0] r_hi);
        logic [4:0] q5;
        logic [8:0] prod;
        q5   = ps_hi[5] ? ~ps_hi[4:0] : ps_hi[4:0];
        prod = {4'b0, q5} * {5'b0, r_hi};
        return (prod >> 1) + 9'd4;
    endfunction

    assign unused_pstate_lsb = ^pState_in[1:0];
    assign bin_ready   = (state == IDLE) && !flush_pend;
    assign m_range_out = range_q;
    assign m_low_out   = low_q;

    // Next-state, coder arithmetic and bit emission decisions
    always_comb begin
        state_nxt      = state;
        ret_nxt        = ret_state;
        range_nxt      = range_q;
        low_nxt        = low_q;
        outs_nxt       = outs_q;
        first_nxt      = first_bit;
        flushing_nxt   = flushing;
        flush_pend_nxt = flush_pend;
        tail_nxt       = tail_phase;
        emit_val_nxt   = emit_val;
        ovf_nxt        = overflow_err;
        bv_nxt         = 1'b0;
        bo_nxt         = 1'b0;
        last_nxt       = 1'b0;
        put_req        = 1'b0;
        put_b          = 1'b0;
        inc_req        = 1'b0;
        after_put      = IDLE;
        lps            = '0;
        rmps           = '0;
        low_sum        = '0;
        byp_t          = '0;
        ren_l          = '0;
        case (state)
            IDLE: begin
                if (flush_pend || (!bin_valid && flush)) begin
                    low_sum        = {1'b0, low_q} + {2'b0, range_q} - 11'd2;
                    low_nxt        = low_sum[9:0];
                    range_nxt      = 9'd2;
                    flushing_nxt   = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = RENORM;
                end else if (bin_valid) begin
                    // a flush arriving with a bin waits until the bin is fully coded
                    flush_pend_nxt = flush;
                    if (bypass) begin
                        byp_t     = {low_q, 1'b0} + (bin_in ? {2'b0, range_q} : 11'd0);
                        after_put = IDLE;
                        if (byp_t >= 11'd1024) begin
                            put_req = 1'b1;
                            put_b   = 1'b1;
                            low_nxt = byp_t[9:0];
                        end else if (byp_t < 11'd512) begin
                            put_req = 1'b1;
                            low_nxt = byp_t[9:0];
                        end else begin
                            inc_req = 1'b1;
                            low_nxt = byp_t[9:0] - 10'd512;
                        end
                    end else begin
                        lps  = lps_range(pState_in[7:2], range_q[8:5]);
                        rmps = range_q - lps;
                        if (bin_in != pState_in[7]) begin
                            low_sum   = {1'b0, low_q} + {2'b0, rmps};
                            low_nxt   = low_sum[9:0];
                            range_nxt = lps;
                        end else begin
                            range_nxt = rmps;
                        end
                        if (!range_nxt[8]) state_nxt = RENORM;
                    end
                end
            end
            RENORM: begin
                if (low_q < 10'd256) begin
                    put_req = 1'b1;
                    ren_l   = low_q;
                end else if (low_q >= 10'd512) begin
                    put_req = 1'b1;
                    put_b   = 1'b1;
                    ren_l   = low_q - 10'd512;
                end else begin
                    inc_req = 1'b1;
                    ren_l   = low_q - 10'd256;
                end
                range_nxt = {range_q[7:0], 1'b0};
                low_nxt   = {ren_l[8:0], 1'b0};
                if (!range_nxt[8])  state_nxt = RENORM;
                else if (flushing)  state_nxt = FLUSH_TAIL;
                else                state_nxt = IDLE;
                after_put = state_nxt;
            end
            EMIT: begin
                bv_nxt   = 1'b1;
                bo_nxt   = emit_val;
                outs_nxt = outs_q - OUTS_ONE;
                if (outs_q == OUTS_ONE) state_nxt = ret_state;
            end
            FLUSH_TAIL: begin
                case (tail_phase)
                    2'd0: begin
                        put_req   = 1'b1;
                        put_b     = low_q[9];
                        after_put = FLUSH_TAIL;
                        tail_nxt  = 2'd1;
                    end
                    2'd1: begin
                        bv_nxt   = 1'b1;
                        bo_nxt   = low_q[8];
                        tail_nxt = 2'd2;
                    end
                    default: begin
                        bv_nxt       = 1'b1;
                        bo_nxt       = 1'b1;
                        last_nxt     = 1'b1;
                        state_nxt    = IDLE;
                        range_nxt    = 9'd510;
                        low_nxt      = '0;
                        first_nxt    = 1'b1;
                        flushing_nxt = 1'b0;
                        tail_nxt     = 2'd0;
                    end
                endcase
            end
            default: state_nxt = IDLE;
        endcase

        // outstanding-bit counter saturates rather than wrapping
        if (inc_req) begin
            if (outs_q == OUTS_MAX) ovf_nxt  = 1'b1;
            else                    outs_nxt = outs_q + OUTS_ONE;
        end
        // PUT: first bit of a stream is swallowed; pending outstanding bits drain in EMIT
        if (put_req) begin
            if (first_bit) begin
                first_nxt = 1'b0;
            end else begin
                bv_nxt = 1'b1;
                bo_nxt = put_b;
            end
            if (outs_q != '0) begin
                emit_val_nxt = ~put_b;
                ret_nxt      = after_put;
                state_nxt    = EMIT;
            end
        end
    end

    // State and output registers; reset wins in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            range_q      <= 9'd510;
            low_q        <= '0;
            outs_q       <= '0;
            first_bit    <= 1'b1;
            flushing     <= 1'b0;
            flush_pend   <= 1'b0;
            tail_phase   <= 2'd0;
            emit_val     <= 1'b0;
            overflow_err <= 1'b0;
            bit_valid    <= 1'b0;
            bit_out      <= 1'b0;
            last_q       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            ret_state    <= ret_nxt;
            range_q      <= range_nxt;
            low_q        <= low_nxt;
            outs_q       <= outs_nxt;
            first_bit    <= first_nxt;
            flushing     <= flushing_nxt;
            flush_pend   <= flush_pend_nxt;
            tail_phase   <= tail_nxt;
            emit_val     <= emit_val_nxt;
            overflow_err <= ovf_nxt;
            bit_valid    <= bv_nxt;
            bit_out      <= bo_nxt;
            last_q       <= last_nxt;
            done         <= last_q;
        end
    end
endmodule

// File: tb/tb_cabac_bin_encoder.sv
// Directed bench for cabac_bin_encoder with hand-computed expectations.
module tb_cabac_bin_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bin_valid = 1'b0;
    logic       bin_ready;
    logic       bin_in = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] pState_in = 8'h00;
    logic       flush = 1'b0;
    logic       bit_out, bit_valid, done, overflow_err;
    logic [8:0] m_range_out;
    logic [9:0] m_low_out;

    int n_chk  = 0;
    int n_pass = 0;

    cabac_bin_encoder #(.OUTS_W(16)) dut (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_in(bin_in), .bypass(bypass), .pState_in(pState_in), .flush(flush),
        .bit_out(bit_out), .bit_valid(bit_valid), .done(done),
        .overflow_err(overflow_err), .m_range_out(m_range_out), .m_low_out(m_low_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; bin_valid = 1'b0; flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_bin(input logic byp, input logic b, input logic [7:0] ps);
        bin_valid = 1'b1; bypass = byp; bin_in = b; pState_in = ps;
        tick();
        bin_valid = 1'b0;
    endtask

    // gather emitted bits (first bit ends up in the MSB) until done, bounded
    task automatic collect(output int nb, output logic [15:0] stream, output logic got_done);
        nb = 0; stream = '0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            tick();
            if (bit_valid) begin
                stream = {stream[14:0], bit_out};
                nb++;
            end
            if (done) got_done = 1'b1;
        end
    endtask

    initial begin
        int         nb;
        logic [15:0] stream;
        logic       got_done;
        logic       any_bv;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_range", 32'(m_range_out), 32'd510);
        chk("rst_low", 32'(m_low_out), 32'd0);
        chk("rst_ready", 32'(bin_ready), 32'd1);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);

        // MPS regular bin, lps=4, no renorm
        do_reset();
        send_bin(1'b0, 1'b0, 8'h00);
        chk("mps_range", 32'(m_range_out), 32'd506);
        chk("mps_low", 32'(m_low_out), 32'd0);
        chk("mps_ready", 32'(bin_ready), 32'd1);
        chk("mps_bv", 32'(bit_valid), 32'd0);

        // LPS regular bin, lps=236, one renorm step raising outs
        do_reset();
        send_bin(1'b0, 1'b1, 8'h7C);
        chk("lps_range", 32'(m_range_out), 32'd236);
        chk("lps_low", 32'(m_low_out), 32'd274);
        chk("lps_ready_low", 32'(bin_ready), 32'd0);
        tick();
        chk("ren_range", 32'(m_range_out), 32'd472);
        chk("ren_low", 32'(m_low_out), 32'd36);
        chk("ren_outs", 32'(dut.outs_q), 32'd1);
        chk("ren_bv", 32'(bit_valid), 32'd0);
        chk("ren_ready", 32'(bin_ready), 32'd1);

        // two bypass bins
        do_reset();
        send_bin(1'b1, 1'b1, 8'h00);
        chk("byp1_low", 32'(m_low_out), 32'd510);
        chk("byp1_range", 32'(m_range_out), 32'd510);
        chk("byp1_bv", 32'(bit_valid), 32'd0);
        send_bin(1'b1, 1'b0, 8'h00);
        chk("byp2_low", 32'(m_low_out), 32'd508);
        chk("byp2_outs", 32'(dut.outs_q), 32'd1);
        chk("byp2_bv", 32'(bit_valid), 32'd0);

        // flush straight after reset: 1111111 0 1
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        collect(nb, stream, got_done);
        chk("flush_done_seen", 32'(got_done), 32'd1);
        chk("flush_nbits", 32'(nb), 32'd9);
        chk("flush_stream", 32'(stream), 32'h1FD);
        chk("flush_done_bv", 32'(bit_valid), 32'd0);
        chk("flush_range", 32'(m_range_out), 32'd510);
        chk("flush_low", 32'(m_low_out), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd0);

        // bin and flush together: bin first, then flush from range=506
        do_reset();
        bin_valid = 1'b1; bypass = 1'b0; bin_in = 1'b0; pState_in = 8'h00; flush = 1'b1;
        tick();
        bin_valid = 1'b0; flush = 1'b0;
        chk("bf_bin_range", 32'(m_range_out), 32'd506);
        chk("bf_ready", 32'(bin_ready), 32'd0);
        tick();
        chk("bf_flush_range", 32'(m_range_out), 32'd2);
        chk("bf_flush_low", 32'(m_low_out), 32'd504);
        collect(nb, stream, got_done);
        chk("bf_done_seen", 32'(got_done), 32'd1);
        chk("bf_nbits", 32'(nb), 32'd9);
        chk("bf_stream", 32'(stream), 32'h1F9);

        // outstanding counter saturation
        do_reset();
        for (int i = 0; i < 8; i++) send_bin(1'b1, 1'b1, 8'h00);
        chk("sat_setup_low", 32'(m_low_out), 32'd2);
        chk("sat_setup_outs", 32'(dut.outs_q), 32'd0);
        bin_valid = 1'b1; bypass = 1'b1; bin_in = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        bin_valid = 1'b0;
        chk("sat_outs_max", 32'(dut.outs_q), 32'd65535);
        chk("sat_ovf_before", 32'(overflow_err), 32'd0);
        chk("sat_low", 32'(m_low_out), 32'd2);
        send_bin(1'b1, 1'b1, 8'h00);
        chk("sat_outs_hold", 32'(dut.outs_q), 32'd65535);
        chk("sat_ovf_set", 32'(overflow_err), 32'd1);
        send_bin(1'b1, 1'b1, 8'h00);
        tick();
        chk("sat_ovf_sticky", 32'(overflow_err), 32'd1);
        do_reset();
        chk("sat_ovf_cleared", 32'(overflow_err), 32'd0);

        // reset while draining outstanding bits
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (9) tick();
        chk("emit_bv", 32'(bit_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_bv", 32'(bit_valid), 32'd0);
        chk("mid_rst_ready", 32'(bin_ready), 32'd1);
        chk("mid_rst_range", 32'(m_range_out), 32'd510);
        chk("mid_rst_low", 32'(m_low_out), 32'd0);
        reset = 1'b0;
        any_bv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_bv = any_bv | bit_valid;
        end
        chk("mid_rst_quiet", 32'(any_bv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
